// File: rtl/fecg_pkg.sv
// fecg_pkg: definitions shared by the fetal ECG datapath blocks.
//   state_t    : phases of the streaming Frobenius normaliser
//   clog2      : ceiling log2, usable in parameter expressions
//   acc_width  : width of a sum of n squared data_w-bit signed values
//   norm_width : width of the integer square root of an acc_w-bit value
package fecg_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SQRT = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + clog2(n);
  endfunction

  function automatic int norm_width(input int acc_w);
    return (acc_w + 1) / 2;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle,
// MSB first, Q_W cycles per division.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : first step; operands are consumed combinationally this cycle
//   dividend_i  : unsigned dividend (quotient must fit in Q_W bits)
//   divisor_i   : unsigned divisor
//   busy_o      : steps 2..Q_W in progress
//   done_o      : high during the final step; quotient_o is valid next cycle
//   quotient_o  : quotient, held until the next start
module serial_divider
  import fecg_pkg::*;
#(
  parameter int DVD_W = 31,
  parameter int DSR_W = 19,
  parameter int Q_W   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DSR_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int SD_W   = DSR_W + Q_W - 1;
  localparam int WORK_W = (DVD_W > SD_W) ? DVD_W : SD_W;
  localparam int CNT_W  = (clog2(Q_W) < 1) ? 1 : clog2(Q_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(Q_W - 1);

  logic [WORK_W-1:0] rem_q, sd_q;
  logic [Q_W-1:0]    quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;

  logic [WORK_W-1:0] cur_rem, cur_sd;
  logic [Q_W-1:0]    cur_quo;
  logic [CNT_W-1:0]  cur_cnt;
  logic              step_en, take;

  // The start cycle already performs the first step on the raw operands, so
  // the whole division occupies exactly Q_W cycles including the start cycle.
  assign cur_rem = start_i ? WORK_W'(dividend_i) : rem_q;
  assign cur_sd  = start_i ? (WORK_W'(divisor_i) << (Q_W - 1)) : sd_q;
  assign cur_quo = start_i ? '0 : quo_q;
  assign cur_cnt = start_i ? '0 : cnt_q;
  assign step_en = start_i | run_q;
  assign take    = cur_rem >= cur_sd;
  assign done_o  = step_en && (cur_cnt == LAST_STEP);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      sd_q  <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (step_en) begin
      rem_q <= take ? (cur_rem - cur_sd) : cur_rem;
      sd_q  <= cur_sd >> 1;
      quo_q <= Q_W'({cur_quo, take});
      cnt_q <= cur_cnt + CNT_W'(1);
      run_q <= !done_o;
    end
  end

  assign busy_o     = run_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/frob_normalize.sv
// frob_normalize: streaming matrix normaliser. Loads a SIZE_A x SIZE_B signed
// matrix row-major, computes floor(sqrt(sum x^2)) bit-serially, then emits
// every element divided by that norm as a signed FRAC_W-fraction value.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : element input handshake (ready only while loading)
//   in_data             : signed element
//   out_valid/out_ready : normalised element handshake
//   out_data            : signed element/norm, FRAC_W fraction bits
//   out_last            : marks the N-th output element
//   norm                : most recently computed norm
//   busy                : high while not accepting a matrix
module frob_normalize
  import fecg_pkg::*;
#(
  parameter int  SIZE_A = 8,
  parameter int  SIZE_B = 8,
  parameter int  DATA_W = 16,
  parameter int  FRAC_W = 14,
  parameter int  OUT_W  = 16,
  localparam int N      = SIZE_A * SIZE_B,
  localparam int ACC_W  = acc_width(DATA_W, N),
  localparam int NORM_W = norm_width(ACC_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic [NORM_W-1:0]        norm,
  output logic                     busy
);

  localparam int IDX_W = clog2(N);
  localparam int SQC_W = clog2(NORM_W);
  localparam int REM_W = NORM_W + 2;
  localparam int PAD_W = 2 * NORM_W;
  localparam int MAG_W = DATA_W + 1;
  localparam int DVD_W = MAG_W + FRAC_W;
  localparam int Q_W   = FRAC_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [SQC_W-1:0] SQ_FIRST = SQC_W'(NORM_W - 1);

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [NORM_W-1:0]         norm_q, norm_d;
  logic [NORM_W-1:0]         root_q, root_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [SQC_W-1:0]          sq_cnt_q, sq_cnt_d;
  logic signed [DATA_W-1:0]  elem_q [N];

  // Squaring of the incoming element (always non-negative).
  logic signed [2*DATA_W-1:0] in_ext, in_sq;
  assign in_ext = (2*DATA_W)'(in_data);
  assign in_sq  = in_ext * in_ext;

  // Square root step: bring down the next two accumulator bits (MSB pair
  // first) and try appending a 1 to the partial root.
  logic [PAD_W-1:0]  acc_pad;
  logic [1:0]        sq_pair;
  logic [REM_W-1:0]  sq_rem_sh, sq_trial, sq_rem_nxt;
  logic [NORM_W-1:0] sq_root_nxt;
  logic              sq_take;

  assign acc_pad     = PAD_W'(acc_q);
  assign sq_pair     = 2'(acc_pad >> {sq_cnt_q, 1'b0});
  assign sq_rem_sh   = REM_W'({rem_q, sq_pair});
  assign sq_trial    = {root_q, 2'b01};
  assign sq_take     = sq_rem_sh >= sq_trial;
  assign sq_rem_nxt  = sq_take ? (sq_rem_sh - sq_trial) : sq_rem_sh;
  assign sq_root_nxt = NORM_W'({root_q, sq_take});

  // Element under division: magnitude in, sign reapplied on the way out.
  logic signed [DATA_W-1:0] cur_elem;
  logic signed [MAG_W-1:0]  elem_ext;
  logic [MAG_W-1:0]         elem_mag;
  logic                     elem_neg;

  assign cur_elem = elem_q[idx_q];
  assign elem_neg = cur_elem[DATA_W-1];
  assign elem_ext = MAG_W'(cur_elem);
  assign elem_mag = elem_neg ? $unsigned(-elem_ext) : $unsigned(elem_ext);

  logic             div_start, div_busy, div_done;
  logic [DVD_W-1:0] div_dividend;
  logic [Q_W-1:0]   div_quot;

  assign div_dividend = {elem_mag, {FRAC_W{1'b0}}};
  assign div_start    = (state_q == S_DIV) && !div_busy;

  serial_divider #(
    .DVD_W (DVD_W),
    .DSR_W (NORM_W),
    .Q_W   (Q_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (norm_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    norm_d   = norm_q;
    root_d   = root_q;
    rem_d    = rem_q;
    sq_cnt_d = sq_cnt_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_W'($unsigned(in_sq));
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            root_d   = '0;
            rem_d    = '0;
            sq_cnt_d = SQ_FIRST;
            state_d  = S_SQRT;
          end
        end
      end
      S_SQRT: begin
        root_d   = sq_root_nxt;
        rem_d    = sq_rem_nxt;
        sq_cnt_d = sq_cnt_q - SQC_W'(1);
        if (sq_cnt_q == '0) begin
          norm_d  = sq_root_nxt;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (div_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_DIV;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      acc_q    <= '0;
      norm_q   <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      norm_q   <= norm_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  // NOTE: the element buffer has no reset; it is always fully rewritten in
  // LOAD before any entry is read, and leaving it out keeps it a plain array.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) elem_q[idx_q] <= in_data;
  end

  // An all-zero matrix has norm 0; the divider still runs but its result is
  // meaningless, so the output is forced to zero.
  logic signed [OUT_W-1:0] quot_ext;
  assign quot_ext = OUT_W'(div_quot);

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = (out_valid && norm_q != '0) ? (elem_neg ? -quot_ext : quot_ext) : '0;
  assign norm      = norm_q;

endmodule

// File: tb/tb_frob_normalize.sv
// Self-checking bench for frob_normalize (default 8x8, 16-bit in, Q1.14 out).
module tb_frob_normalize;

  localparam int N      = 64;
  localparam int NORM_W = 19;
  localparam int FRAC_W = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               out_last;
  logic [NORM_W-1:0]  norm;
  logic               busy;

  frob_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .norm      (norm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     mat [N];
  int     exp_data[$];
  longint exp_norm[$];
  int     got_data [N];

  function automatic longint isqrt(input longint s);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 20;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic push_model();
    longint sum, nrm, mag;
    sum = 0;
    for (int i = 0; i < N; i++) sum += longint'(mat[i]) * longint'(mat[i]);
    nrm = isqrt(sum);
    exp_norm.push_back(nrm);
    for (int i = 0; i < N; i++) begin
      if (nrm == 0) begin
        exp_data.push_back(0);
      end else begin
        mag = ((mat[i] < 0 ? -longint'(mat[i]) : longint'(mat[i])) << FRAC_W) / nrm;
        exp_data.push_back(int'(mat[i] < 0 ? -mag : mag));
      end
    end
  endtask

  // ---------------- output compare process ----------------
  int                 elem_cnt = 0;
  int                 mats_done = 0;
  int                 low_cnt = 0;
  bit                 gap_armed = 1'b0;
  bit                 prev_stall = 1'b0;
  logic signed [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data.delete();
      exp_norm.delete();
      elem_cnt   = 0;
      low_cnt    = 0;
      gap_armed  = 1'b0;
      prev_stall = 1'b0;
    end else if (out_valid) begin
      if (exp_data.size() == 0 || exp_norm.size() == 0) begin
        check("unexpected output", 1, 0);
      end else begin
        check($sformatf("out_data[%0d]", elem_cnt), out_data, exp_data[0]);
        check($sformatf("out_last[%0d]", elem_cnt), out_last, elem_cnt == N - 1);
        if (elem_cnt == 0) check("norm", norm, exp_norm[0]);
        if (prev_stall) check("out_data held under backpressure", out_data, prev_data);
        if (gap_armed) check("gap cycles", low_cnt, FRAC_W + 1);
        gap_armed  = 1'b0;
        prev_stall = !out_ready;
        prev_data  = out_data;
        if (out_ready) begin
          got_data[elem_cnt] = int'(out_data);
          void'(exp_data.pop_front());
          elem_cnt++;
          low_cnt   = 0;
          gap_armed = 1'b1;
          if (elem_cnt == N) begin
            elem_cnt  = 0;
            gap_armed = 1'b0;
            void'(exp_norm.pop_front());
            mats_done++;
          end
        end
      end
    end else begin
      if (prev_stall) check("out_valid held under backpressure", out_valid, 1);
      prev_stall = 1'b0;
      low_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit ready_rand = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Returns 1 time unit after the edge that accepted the N-th element.
  task automatic send_matrix(input bit gaps);
    int i, budget;
    push_model();
    i = 0;
    budget = 0;
    while (i < N && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 16'(mat[i]);
        if (in_ready) i++;
      end
    end
    if (i < N) check("load stalled", i, N);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (mats_done < target && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("matrices completed", mats_done, target);
  endtask

  task automatic measure_first_valid(input int exp_lat);
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first out_valid latency", k, exp_lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_last"}, out_last, 0);
    check({tag, " norm"}, norm, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) mat[i] = v;
  endtask

  int done_target = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1);

    // Single element 100 at (2,3)
    fill(0);
    mat[2*8+3] = 100;
    send_matrix(1'b0);
    check("in_ready after last accept", in_ready, 0);
    check("busy after last accept", busy, 1);
    done_target++;
    wait_done(done_target);
    check("in_ready after final handshake", in_ready, 1);
    check("lit norm single", norm, 100);
    check("lit out (2,3)", got_data[19], 16384);
    check("lit out (0,0)", got_data[0], 0);
    repeat (5) @(posedge clk);
    #1;
    check("norm retained in LOAD", norm, 100);

    // All threes
    fill(3);
    send_matrix(1'b0);
    measure_first_valid(NORM_W + FRAC_W + 1);
    done_target++;
    wait_done(done_target);
    check("lit norm threes", norm, 24);
    check("lit out threes first", got_data[0], 2048);
    check("lit out threes last", got_data[63], 2048);

    // -5, 12: truncation toward zero
    fill(0);
    mat[0] = -5;
    mat[1] = 12;
    send_matrix(1'b1);
    done_target++;
    wait_done(done_target);
    check("lit norm 5-12-13", norm, 13);
    check("lit out -5/13", got_data[0], -6301);
    check("lit out 12/13", got_data[1], 15123);
    check("lit out zero", got_data[2], 0);

    // All zero
    fill(0);
    send_matrix(1'b0);
    measure_first_valid(NORM_W + FRAC_W + 1);
    done_target++;
    wait_done(done_target);
    check("lit norm zero", norm, 0);
    check("lit out zero matrix", got_data[37], 0);

    // Random data, input gaps, random backpressure
    ready_rand = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) mat[i] = int'($urandom_range(0, 65535)) - 32768;
      send_matrix(1'b1);
      done_target++;
      wait_done(done_target);
    end
    ready_rand = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of dividing element 10
    fill(3);
    send_matrix(1'b0);
    begin
      int k;
      k = 0;
      while (elem_cnt < 10 && k < 2000) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("reached element 10", elem_cnt, 10);
    end
    @(posedge clk);
    #1;
    check("mid-DIV busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill(3);
    send_matrix(1'b0);
    done_target++;
    wait_done(done_target);
    check("lit norm after reset", norm, 24);
    check("lit out after reset", got_data[10], 2048);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frob_normalize.md
# frob_normalize

Streaming matrix normaliser: accepts a SIZE_A×SIZE_B signed integer matrix element by element, computes its integer Frobenius norm floor(sqrt(Σx²)), then emits every element divided by that norm as a signed fixed-point value. It sits downstream of the whitening/ICA stages in the fetal ECG datapath. It is the consumer of a Frobenius norm, applying the norm back onto the matrix, and it replaces the real-valued combinational norm with a fully sequential integer implementation.

## Interface
- SIZE_A, 8, matrix rows
- SIZE_B, 8, matrix columns
- DATA_W, 16, signed input element width
- FRAC_W, 14, output fraction bits; require OUT_W ≥ FRAC_W+2
- OUT_W, 16, signed output width
- Derived: N = SIZE_A·SIZE_B; ACC_W = 2·DATA_W + clog2(N) (38); NORM_W = ceil(ACC_W/2) (19)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts input (LOAD state)
- in_data  in  DATA_W  signed element, row-major order
- out_valid  out  1  normalised element valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_W  signed element/norm, FRAC_W fraction bits
- out_last  out  1  high with final (N-th) output element
- norm  out  NORM_W  last computed norm, unsigned
- busy  out  1  high in SQRT, DIV, OUT

## Operation
- States: LOAD, SQRT, DIV, OUT.
- LOAD: in_ready=1. Each in_valid&in_ready stores in_data into buf[idx], adds in_data² to the ACC_W accumulator, and increments idx. After the N-th accept, the next state is SQRT, idx resets to 0, and the accumulator is held.
- SQRT: bit-serial restoring integer square root, one result bit per cycle, MSB first; exactly NORM_W cycles. At exit, norm is updated to floor(sqrt(acc)).
- DIV: for element buf[idx], restoring division of |x|<<FRAC_W by norm, one quotient bit per cycle; exactly FRAC_W+1 cycles. Quotient ≤ 2^FRAC_W is guaranteed, because |x| ≤ floor(sqrt(Σx²)). The quotient truncates toward zero, and the sign of x is reapplied.
- norm == 0 (all-zero matrix): DIV still runs FRAC_W+1 cycles, and the result is forced to 0.
- OUT: out_valid=1 and out_data is stable until out_ready. On handshake: if idx < N-1, idx++ and go to DIV; else clear the accumulator and go to LOAD.
- out_last = out_valid && idx == N-1.
- Reset (any state, including mid-operation): state goes to LOAD, idx/accumulator/norm go to 0, out_valid/out_last/out_data go to 0, busy goes to 0. Partial matrices are discarded. The buffer contents need no reset.

## Timing
- Reset values: in_ready=1 (after rst_n deassert), out_valid=0, out_data=0, out_last=0, norm=0, busy=0.
- Load: ≥N cycles. in_valid gaps are allowed, and in_data is ignored when in_ready=0.
- Cycle after the N-th accept: state=SQRT, in_ready=0, busy=1.
- SQRT → DIV after NORM_W cycles. norm changes on the SQRT→DIV edge.
- First out_valid rises NORM_W + FRAC_W + 1 cycles after the SQRT entry cycle.
- Each subsequent element: out_valid is low for exactly FRAC_W+1 cycles after the previous handshake.
- Backpressure: OUT may persist indefinitely, with out_data and out_last held.
- After the final handshake: in_ready=1 on the next cycle, and norm retains its value until the next SQRT exit.

## Structure
- The shared package fecg_pkg holds the state enum (LOAD/SQRT/DIV/OUT) and width-derivation functions (clog2, ACC_W/NORM_W computation).
- Natural sub-module: serial_divider (start/done, dividend/divisor in, quotient out, FRAC_W+1 cycles). The square root stays inline in the top FSM.
- The element buffer is an N×DATA_W register array, indexed by a clog2(N) counter shared between LOAD and DIV/OUT.

## Test plan
- Single non-zero element 100 at (2,3), rest 0 → norm=100; that output is 16384, the other 63 outputs are 0; out_last on the 64th only.
- All 64 elements = 3 → norm=24; every out_data=2048; first out_valid 19+15 cycles after SQRT entry.
- Elements -5 at (0,0), 12 at (0,1), rest 0 → norm=13; outputs -6301, 15123, then 0×62 (truncation toward zero).
- All-zero matrix → norm=0; 64 outputs of 0, no X; timing identical to the non-zero case.
- Random out_ready (~30% duty) with random in_valid gaps, random signed data → outputs match the reference model bit-exactly; out_data is stable while out_valid&!out_ready.
- rst_n pulsed low mid-DIV of element 10 → outputs return to reset values immediately; next full matrix (all 3) yields norm=24 and 64×2048 with no residue.
